phy_stim_chk: RTL and testbench

- Synthesizable, parametrised PHY stimulus generator and loopback checker. It replaces the fixed four-lane, hand-written bench stimulus.
- Drives LANES parallel words, each DW data bits plus a valid MSB, into the PHY transmit side.
- Regenerates the same sequence locally and compares it against the PHY receive-side words.
- Reports per-lane error flags, a saturating error count, and a lock timeout.

---
 rtl/phy_stim_pkg.sv | 30 +++
 rtl/phy_stim_chk_pat.sv | 65 ++++++
 rtl/phy_stim_chk.sv | 212 +++++++++++++++++++++
 tb/tb_phy_stim_chk.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_stim_pkg.sv
// Shared types and constants for the PHY stimulus generator / loopback checker.
//   mode_e    : pattern selection (fixed, counter, LFSR, counter with valid gaps)
//   state_e   : run-control FSM states
//   LFSR_POLY : Galois toggle mask for x^8+x^6+x^5+x^4+1 (right-shift form)
//   FIXED_WORD: constant pattern for mode 0
//   slice_w() : width of one lane slice (data bits plus the valid MSB)
package phy_stim_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_CNT   = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_GAP   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GEN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam logic [7:0] LFSR_POLY  = 8'hB8;
   localparam logic [7:0] FIXED_WORD = 8'hBC;

   function automatic int unsigned slice_w(input int unsigned dw);
      return dw + 1;
   endfunction

endpackage

// File: rtl/phy_stim_chk_pat.sv
// Per-lane pattern word generator (used for both transmit and expected words).
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   init_i         : reload the LFSR with the lane seed (when not advancing)
//   adv_i          : step the LFSR to the next word
//   idx_i          : word index i
//   mode_i         : pattern mode (mode_e encoding)
//   word_c_o       : combinational {valid, data} for the current index / LFSR state
module phy_pat_word
   import phy_stim_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned LANE  = 0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             init_i,
   input  logic             adv_i,
   input  logic [CNT_W-1:0] idx_i,
   input  logic [1:0]       mode_i,
   output logic [DW:0]      word_c_o
);

   localparam logic [DW-1:0] SEED  = DW'(LANE + 1);
   localparam logic [DW-1:0] POLY  = DW'(LFSR_POLY);
   localparam logic [DW-1:0] FIXED = DW'(FIXED_WORD);

   logic [DW-1:0] lfsr_q, lfsr_d;
   logic [DW-1:0] data;
   logic          valid;

   // Advancing wins over reloading so the acceptance edge can step from the seed.
   always_comb begin
      lfsr_d = lfsr_q;
      if (adv_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
      end else if (init_i) begin
         lfsr_d = SEED;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Word pattern selection.
   always_comb begin
      data  = DW'(idx_i) + DW'(LANE);
      valid = 1'b1;
      case (mode_i)
         MODE_FIXED: data  = FIXED;
         MODE_CNT:   data  = DW'(idx_i) + DW'(LANE);
         MODE_LFSR:  data  = lfsr_q;
         MODE_GAP:   valid = (idx_i[1:0] != 2'd3);
         default:    data  = DW'(idx_i) + DW'(LANE);
      endcase
      word_c_o = {valid, data};
   end

endmodule

// File: rtl/phy_stim_chk.sv
// PHY stimulus generator and loopback checker.
// Drives LANES words of {valid, DW data} onto paralelo, regenerates the same
// sequence locally, locks on the first valid lane-0 loopback word and compares.
// Ports:
//   clkf, reset          : clock, synchronous active-high reset
//   start, mode,
//   num_words            : run request, pattern mode, words per lane
//   inject               : error-injection request (PHY_STIM_ERR_INJECT_EN)
//   paralelo / loopback  : transmit / receive lane words, lane n at [n*(DW+1) +: DW+1]
//   busy, done, timeout  : run status, end-of-run pulse, sticky lock failure
//   err_lane, err_cnt    : sticky per-lane mismatch flags, saturating mismatch count
// Optional build macro: PHY_STIM_ERR_INJECT_EN enables lane-0 bit-0 error injection.
module phy_stim_chk
   import phy_stim_pkg::*;
#(
   parameter int unsigned LANES   = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned LAT_MAX = 64,
   parameter int unsigned ERR_W   = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                     clkf,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic [CNT_W-1:0]         num_words,
   input  logic                     inject,
   output logic [LANES*(DW+1)-1:0]  paralelo,
   input  logic [LANES*(DW+1)-1:0]  loopback,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [LANES-1:0]         err_lane,
   output logic [ERR_W-1:0]         err_cnt
);

   localparam int unsigned SW    = slice_w(DW);
   localparam int unsigned BUS_W = LANES * SW;
   localparam int unsigned LAT_W = $clog2(LAT_MAX + 1);
   localparam int unsigned SUM_W = ERR_W + 1;

   state_e             state_q;
   logic [1:0]         mode_q;
   logic [CNT_W-1:0]   num_q;
   logic [CNT_W-1:0]   gi_q;
   logic [CNT_W-1:0]   ci_q;
   logic               lk_q;
   logic [LAT_W-1:0]   lat_q;
   logic [BUS_W-1:0]   par_q;
   logic               busy_q;
   logic               done_q;
   logic               tmo_q;
   logic [LANES-1:0]   errl_q;
   logic [ERR_W-1:0]   errc_q;

   logic               accept, run_st, emit, lock_now, tmo_now, cmp_en, inj_flip;
   logic [CNT_W-1:0]   gen_idx, chk_idx;
   logic [1:0]         gen_mode;
   logic [BUS_W-1:0]   gen_bus, chk_bus, gen_word;
   logic [LANES-1:0]   mism;
   logic [SUM_W-1:0]   err_sum;
   logic [ERR_W-1:0]   err_next;

   assign accept = (state_q == ST_IDLE) && start;
   assign run_st = (state_q == ST_GEN) || (state_q == ST_DRAIN);
   assign emit   = (accept && (num_words != '0)) || ((state_q == ST_GEN) && (gi_q < num_q));

   // Word 0 is produced on the acceptance edge, before mode/num are latched.
   assign gen_idx  = (state_q == ST_IDLE) ? '0 : gi_q;
   assign gen_mode = (state_q == ST_IDLE) ? mode : mode_q;
   assign chk_idx  = lk_q ? ci_q : '0;

   // Lock on the first valid lane-0 word; give up after LAT_MAX unlocked cycles.
   assign lock_now = run_st && !lk_q && loopback[DW];
   assign tmo_now  = run_st && !lk_q && !loopback[DW] && (lat_q == LAT_W'(LAT_MAX - 1));
   assign cmp_en   = lock_now || (run_st && lk_q && (ci_q < num_q));

`ifdef PHY_STIM_ERR_INJECT_EN
   assign inj_flip = inject && (state_q == ST_GEN);
`else
   logic unused_inject;
   assign unused_inject = inject;
   assign inj_flip      = 1'b0;
`endif

   assign gen_word = gen_bus ^ BUS_W'(inj_flip);

   for (genvar n = 0; n < int'(LANES); n++) begin : g_lane
      phy_pat_word #(.DW(DW), .CNT_W(CNT_W), .LANE(n)) u_gen (
         .clk_i    (clkf),
         .reset_i  (reset),
         .init_i   (state_q != ST_GEN),
         .adv_i    (emit),
         .idx_i    (gen_idx),
         .mode_i   (gen_mode),
         .word_c_o (gen_bus[n*SW +: SW])
      );
      phy_pat_word #(.DW(DW), .CNT_W(CNT_W), .LANE(n)) u_chk (
         .clk_i    (clkf),
         .reset_i  (reset),
         .init_i   (!lk_q),
         .adv_i    (cmp_en),
         .idx_i    (chk_idx),
         .mode_i   (mode_q),
         .word_c_o (chk_bus[n*SW +: SW])
      );
   end

   // Valid is always compared; data only where the expected word is valid.
   always_comb begin
      mism    = '0;
      err_sum = SUM_W'(errc_q);
      for (int n = 0; n < int'(LANES); n++) begin
         mism[n] = (chk_bus[n*SW + DW] != loopback[n*SW + DW]) ||
                   (chk_bus[n*SW + DW] && (chk_bus[n*SW +: DW] != loopback[n*SW +: DW]));
         err_sum = err_sum + SUM_W'(mism[n]);
      end
      err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   end

   // Run control FSM with registered outputs.
   always_ff @(posedge clkf) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= '0;
         num_q   <= '0;
         gi_q    <= '0;
         ci_q    <= '0;
         lk_q    <= 1'b0;
         lat_q   <= '0;
         par_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         errl_q  <= '0;
         errc_q  <= '0;
      end else begin
         done_q <= 1'b0;

         if (cmp_en) begin
            ci_q   <= lk_q ? ci_q + 1'b1 : CNT_W'(1);
            lk_q   <= 1'b1;
            errl_q <= errl_q | mism;
            errc_q <= err_next;
         end
         if (run_st && !lk_q && !lock_now) begin
            lat_q <= lat_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  num_q  <= num_words;
                  tmo_q  <= 1'b0;
                  errl_q <= '0;
                  errc_q <= '0;
                  ci_q   <= '0;
                  lk_q   <= 1'b0;
                  lat_q  <= '0;
                  if (num_words == '0) begin
                     state_q <= ST_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_GEN;
                     busy_q  <= 1'b1;
                     par_q   <= gen_word;
                     gi_q    <= CNT_W'(1);
                  end
               end
            end
            ST_GEN: begin
               if (tmo_now) begin
                  tmo_q   <= 1'b1;
                  par_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FIN;
               end else if (gi_q < num_q) begin
                  par_q <= gen_word;
                  gi_q  <= gi_q + 1'b1;
               end else begin
                  par_q   <= '0;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (tmo_now || (lk_q && (ci_q == num_q))) begin
                  tmo_q   <= tmo_now;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               lk_q    <= 1'b0;
               gi_q    <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign paralelo = par_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign timeout  = tmo_q;
   assign err_lane = errl_q;
   assign err_cnt  = errc_q;

endmodule

// File: tb/tb_phy_stim_chk.sv
// Self-checking bench for phy_stim_chk: directed vector table, randomized runs
// against a behavioural pattern/error model, reset and injection sequences.
module tb_phy_stim_chk;

   localparam int LN = 4;
   localparam int BW = LN * 9;
`ifdef PHY_STIM_ERR_INJECT_EN
   localparam bit INJ_ON = 1'b1;
`else
   localparam bit INJ_ON = 1'b0;
`endif

   logic           clkf = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [1:0]     mode = '0;
   logic [15:0]    num_words = '0;
   logic           inject = 1'b0;
   logic [BW-1:0]  paralelo;
   logic [BW-1:0]  loopback;
   logic           busy, done, timeout;
   logic [LN-1:0]  err_lane;
   logic [15:0]    err_cnt;

   int             checks = 0;
   int             errors = 0;

   // Loopback channel: delay line plus stuck-at faults or a dead link.
   int             g_d = 0;
   logic [BW-1:0]  g_s1 = '0;
   logic [BW-1:0]  g_s0 = '0;
   bit             g_tie = 1'b0;
   logic [BW-1:0]  hist [0:127];
   logic [BW-1:0]  raw;

   always #5 clkf = ~clkf;

   always @(posedge clkf) begin
      hist[0] <= paralelo;
      for (int k = 1; k < 128; k++) hist[k] <= hist[k-1];
   end

   assign raw      = (g_d == 0) ? paralelo : hist[g_d-1];
   assign loopback = g_tie ? '0 : ((raw | g_s1) & ~g_s0);

   phy_stim_chk #(.LANES(4), .DW(8), .LAT_MAX(64), .ERR_W(16), .CNT_W(16)) dut (
      .clkf      (clkf),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .num_words (num_words),
      .inject    (inject),
      .paralelo  (paralelo),
      .loopback  (loopback),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .err_lane  (err_lane),
      .err_cnt   (err_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected {valid, data} for word i on lane n, straight from the pattern rules.
   function automatic logic [8:0] exp_word(input int m, input int i, input int n);
      logic [7:0] d;
      logic       v;
      int         s;
      v = 1'b1;
      case (m)
         0: d = 8'hBC;
         1: d = 8'((i + n) % 256);
         2: begin
            s = n + 1;
            for (int k = 0; k < i; k++) s = (s % 2 == 1) ? ((s / 2) ^ 'hB8) : (s / 2);
            d = 8'(s);
         end
         3: begin
            d = 8'((i + n) % 256);
            v = ((i % 4) != 3);
         end
         default: d = 8'h00;
      endcase
      return {v, d};
   endfunction

   function automatic logic [BW-1:0] pack(input int m, input int i);
      logic [BW-1:0] p;
      for (int n = 0; n < LN; n++) p[n*9 +: 9] = exp_word(m, i, n);
      return p;
   endfunction

   function automatic void model_errs(input int m, input int num, input logic [BW-1:0] s1,
                                      input logic [BW-1:0] s0, output int cnt,
                                      output logic [LN-1:0] ln);
      logic [8:0] e, r;
      cnt = 0;
      ln  = '0;
      for (int i = 0; i < num; i++) begin
         for (int n = 0; n < LN; n++) begin
            e = exp_word(m, i, n);
            r = (e | s1[n*9 +: 9]) & ~s0[n*9 +: 9];
            if ((e[8] != r[8]) || (e[8] && (e[7:0] != r[7:0]))) begin
               cnt++;
               ln[n] = 1'b1;
            end
         end
      end
   endfunction

   // One complete run: start, per-cycle transmit check, wait for done, check results.
   task automatic run_check(input string nm, input int m, input int num, input int d,
                            input logic [BW-1:0] s1, input logic [BW-1:0] s0, input bit tie,
                            input int inj_k, input int e_cnt, input logic [LN-1:0] e_lane,
                            input bit e_tmo);
      int            ndone;
      int            post;
      logic [BW-1:0] ep;
      g_d   = d;
      g_s1  = s1;
      g_s0  = s0;
      g_tie = tie;
      @(negedge clkf);
      mode      = 2'(m);
      num_words = 16'(num);
      start     = 1'b1;
      @(negedge clkf);
      start = 1'b0;
      ndone = 0;
      post  = 0;
      for (int k = 0; k < num + d + 80; k++) begin
         inject = (k == inj_k);
         if (k < num) begin
            ep = pack(m, k);
            if (INJ_ON && (inj_k >= 0) && (k == inj_k + 1)) ep[0] = ~ep[0];
            chk({nm, " paralelo"}, 64'(paralelo), 64'(ep));
         end else if (k == num) begin
            chk({nm, " paralelo_idle"}, 64'(paralelo), 64'd0);
         end
         if ((k == 0) && (num > 0)) chk({nm, " busy_after_start"}, 64'(busy), 64'd1);
         if (done) begin
            ndone++;
            if (ndone == 1) chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
         end
         if (ndone > 0) post++;
         if (post >= 3) break;
         @(negedge clkf);
      end
      inject = 1'b0;
      chk({nm, " done_pulses"}, 64'(ndone), 64'd1);
      chk({nm, " timeout"}, 64'(timeout), 64'(e_tmo));
      chk({nm, " err_lane"}, 64'(err_lane), 64'(e_lane));
      chk({nm, " err_cnt"}, 64'(err_cnt), 64'(e_cnt));
      repeat (70) @(negedge clkf);
   endtask

   typedef struct {
      string         nm;
      int            m;
      int            num;
      int            d;
      logic [BW-1:0] s1;
      logic [BW-1:0] s0;
      bit            tie;
      int            e_cnt;
      logic [LN-1:0] e_lane;
      bit            e_tmo;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int            rc;
      logic [LN-1:0] rl;
      int            m, num, d, fl, bt, ndone;
      logic [BW-1:0] s1, s0;

      tbl[0] = '{"cnt_direct",   1,  8,  0, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b0};
      tbl[1] = '{"lfsr_dly5",    2,  8,  5, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b0};
      tbl[2] = '{"gap_direct",   3,  8,  0, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b0};
      tbl[3] = '{"dead_link",    1,  8,  0, 36'h0,         36'h0,         1'b1,  0, 4'b0000, 1'b1};
      tbl[4] = '{"l2_b4_stuck1", 1, 16,  0, 36'h000400000, 36'h0,         1'b0, 14, 4'b0100, 1'b0};
      tbl[5] = '{"lock_edge63",  0,  4, 63, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b0};
      tbl[6] = '{"lock_late64",  0,  4, 64, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b1};
      tbl[7] = '{"zero_words",   0,  0,  0, 36'h0,         36'h0,         1'b0,  0, 4'b0000, 1'b0};
      tbl[8] = '{"l1_valid_s0",  2,  5,  2, 36'h0,         36'h000020000, 1'b0,  5, 4'b0010, 1'b0};
      tbl[9] = '{"gap_l3_b0_s1", 3,  8,  1, 36'h008000000, 36'h0,         1'b0,  2, 4'b1000, 1'b0};

      // Reset state.
      repeat (3) @(negedge clkf);
      chk("reset paralelo", 64'(paralelo), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset timeout", 64'(timeout), 64'd0);
      chk("reset err_lane", 64'(err_lane), 64'd0);
      chk("reset err_cnt", 64'(err_cnt), 64'd0);
      reset = 1'b0;
      repeat (130) @(negedge clkf);

      for (int v = 0; v < 10; v++) begin
         run_check(tbl[v].nm, tbl[v].m, tbl[v].num, tbl[v].d, tbl[v].s1, tbl[v].s0,
                   tbl[v].tie, -1, tbl[v].e_cnt, tbl[v].e_lane, tbl[v].e_tmo);
      end

      // Injection on the 3rd GEN cycle corrupts lane 0 of word 3 only when enabled.
      run_check("inject", 1, 8, 0, '0, '0, 1'b0, 2, INJ_ON ? 1 : 0,
                INJ_ON ? 4'b0001 : 4'b0000, 1'b0);

      // Randomized runs against the model.
      for (int r = 0; r < 20; r++) begin
         m   = int'($urandom_range(0, 3));
         num = int'($urandom_range(1, 20));
         d   = int'($urandom_range(0, 10));
         fl  = int'($urandom_range(0, 4));
         bt  = (fl == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 8));
         s1  = '0;
         s0  = '0;
         if (fl < 4) begin
            if ($urandom_range(0, 1) == 1) s1[fl*9 + bt] = 1'b1;
            else                            s0[fl*9 + bt] = 1'b1;
         end
         model_errs(m, num, s1, s0, rc, rl);
         run_check($sformatf("rand%0d", r), m, num, d, s1, s0, 1'b0, -1, rc, rl, 1'b0);
      end

      // Reset in the middle of GEN with errors already counted.
      g_d   = 0;
      g_s1  = 36'h000400000;
      g_s0  = '0;
      g_tie = 1'b0;
      @(negedge clkf);
      mode      = 2'd1;
      num_words = 16'd20;
      start     = 1'b1;
      @(negedge clkf);
      start = 1'b0;
      repeat (4) @(negedge clkf);
      chk("midrun busy", 64'(busy), 64'd1);
      chk("midrun err_cnt", 64'(err_cnt), 64'd4);
      reset = 1'b1;
      @(negedge clkf);
      chk("postreset paralelo", 64'(paralelo), 64'd0);
      chk("postreset busy", 64'(busy), 64'd0);
      chk("postreset done", 64'(done), 64'd0);
      chk("postreset err_lane", 64'(err_lane), 64'd0);
      chk("postreset err_cnt", 64'(err_cnt), 64'd0);
      reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(negedge clkf);
         if (done) ndone++;
      end
      chk("postreset no_done", 64'(ndone), 64'd0);
      run_check("after_reset", 2, 10, 3, '0, '0, 1'b0, -1, 0, 4'b0000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
